scale_matrix: RTL and testbench



---
 rtl/scale_matrix.sv | 44 ++++
 tb/tb_scale_matrix.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/scale_matrix.sv
// Scales each 16-bit element of a packed 4x4 matrix by an 8-bit scalar, registered.
// Optional build macro SCALE_MATRIX_SATURATE_EN clamps overflowing products to 16'hFFFF.
module scale_matrix (
  input  logic         clk,
  input  logic         reset,
  output logic [255:0] m_out,
  output logic         done,
  input  logic [255:0] matrix,
  input  logic [7:0]   scalar,
  input  logic         enable
);

  logic [255:0] w_scaled;
  logic [255:0] r_m_out;
  logic         r_done;

  // Element g = row*4 + col lives at bits g*16 +: 16, so a flat index covers the packing.
  for (genvar g = 0; g < 16; g++) begin : g_elem
`ifdef SCALE_MATRIX_SATURATE_EN
    logic [23:0] w_prod;
    assign w_prod = {8'd0, matrix[g*16 +: 16]} * {16'd0, scalar};
    assign w_scaled[g*16 +: 16] = (|w_prod[23:16]) ? 16'hFFFF : w_prod[15:0];
`else
    // Only the low 16 bits survive the wrap, so a 16-bit product is sufficient.
    assign w_scaled[g*16 +: 16] = matrix[g*16 +: 16] * {8'd0, scalar};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_out <= '0;
      r_done  <= 1'b0;
    end else if (enable) begin
      r_m_out <= w_scaled;
      r_done  <= 1'b1;
    end else begin
      r_done  <= 1'b0;
    end
  end

  assign m_out = r_m_out;
  assign done  = r_done;

endmodule

// File: tb/tb_scale_matrix.sv
// Directed self-checking bench for scale_matrix using immediate assertions.
module tb_scale_matrix;

  logic         clk;
  logic         reset;
  logic [255:0] m_out;
  logic         done;
  logic [255:0] matrix;
  logic [7:0]   scalar;
  logic         enable;

  int n_checks = 0;
  int n_fail   = 0;

  int nom_src[16] = '{5, 8, 9, 2, 7, 3, 8, 4, 6, 5, 4, 3, 8, 5, 7, 6};
  int nom_exp[16] = '{25, 40, 45, 10, 35, 15, 40, 20, 30, 25, 20, 15, 40, 25, 35, 30};

  logic [255:0] exp_m;
  logic [255:0] held_m;

  scale_matrix u_dut (
    .clk    (clk),
    .reset  (reset),
    .m_out  (m_out),
    .done   (done),
    .matrix (matrix),
    .scalar (scalar),
    .enable (enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pack16(input int v[16]);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i*16 +: 16] = 16'(v[i]);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_m(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, expv);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, expv);
    end
  endtask

  initial begin
    int ovf[16];
    reset  = 1'b1;
    enable = 1'b0;
    matrix = '0;
    scalar = 8'd0;

    // Reset
    step();
    chk_m("reset_m_out", m_out, 256'h0);
    chk_b("reset_done", done, 1'b0);
    reset = 1'b0;
    step();
    chk_m("idle_m_out", m_out, 256'h0);
    chk_b("idle_done", done, 1'b0);

    // Nominal, scalar 5
    matrix = pack16(nom_src);
    scalar = 8'd5;
    enable = 1'b1;
    step();
    chk_m("nominal_m_out", m_out, pack16(nom_exp));
    chk_b("nominal_done", done, 1'b1);

    // Zero scalar
    scalar = 8'd0;
    step();
    chk_m("zero_m_out", m_out, 256'h0);
    chk_b("zero_done", done, 1'b1);

    // Identity scalar
    matrix = {64'hFFFF_8000_1234_0001, 64'hABCD_0F0F_00FF_7FFF,
              64'h0000_FFFE_5555_AAAA, 64'h0102_0304_0506_0708};
    scalar = 8'd1;
    step();
    chk_m("identity_m_out", m_out, matrix);
    chk_b("identity_done", done, 1'b1);

    // Overflow: [0][0]=300, [3][3]=FFFF, others 2
    for (int i = 0; i < 16; i++) ovf[i] = 2;
    ovf[0]  = 300;
    ovf[15] = 65535;
    matrix = pack16(ovf);
    scalar = 8'd255;
    step();
    exp_m = '0;
    for (int i = 0; i < 16; i++) exp_m[i*16 +: 16] = 16'd510;
`ifdef SCALE_MATRIX_SATURATE_EN
    exp_m[15:0]    = 16'hFFFF;
    exp_m[255:240] = 16'hFFFF;
`else
    exp_m[15:0]    = 16'd10964;
    exp_m[255:240] = 16'hFF01;
`endif
    chk_w("ovf_elem00", m_out[15:0], exp_m[15:0]);
    chk_w("ovf_elem33", m_out[255:240], exp_m[255:240]);
    chk_m("ovf_m_out", m_out, exp_m);
    chk_b("ovf_done", done, 1'b1);

    // Hold: drop enable, change inputs
    held_m = exp_m;
    enable = 1'b0;
    matrix = pack16(nom_src);
    scalar = 8'd3;
    step();
    chk_m("hold_m_out", m_out, held_m);
    chk_b("hold_done", done, 1'b0);
    step();
    chk_m("hold2_m_out", m_out, held_m);
    chk_b("hold2_done", done, 1'b0);

    // Enable held high tracks input changes each cycle
    enable = 1'b1;
    scalar = 8'd5;
    step();
    chk_m("track1_m_out", m_out, pack16(nom_exp));
    chk_b("track1_done", done, 1'b1);
    scalar = 8'd2;
    step();
    exp_m = '0;
    for (int i = 0; i < 16; i++) exp_m[i*16 +: 16] = 16'(nom_src[i] * 2);
    chk_m("track2_m_out", m_out, exp_m);
    chk_b("track2_done", done, 1'b1);

    // Reset beats enable with nonzero data
    reset = 1'b1;
    scalar = 8'd7;
    step();
    chk_m("rstpri_m_out", m_out, 256'h0);
    chk_b("rstpri_done", done, 1'b0);
    reset  = 1'b0;
    enable = 1'b0;
    step();
    chk_m("post_rst_m_out", m_out, 256'h0);
    chk_b("post_rst_done", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
